interpolation_unit_bilinear_stream: RTL and testbench

Streaming, parametrised bilinear interpolator for the LK tracker. It accepts one feature's fractional offset and then a raster stream of a (W+1)×(W+1) integer-pixel patch. It emits W×W interpolated pixels in raster order, with full val/rdy backpressure on every port. It sits between the patch fetch unit and the gradient/accumulate stage, and it computes the four bilinear weights once per feature.

---
 rtl/interpolation_unit_bilinear_stream_pkg.sv | 33 +++
 rtl/interpolation_unit_bilinear_stream_if.sv | 28 ++
 rtl/interpolation_unit_bilinear_stream_linebuf.sv | 21 ++
 rtl/interpolation_unit_bilinear_stream.sv | 134 +++++++++++++
 tb/tb_interpolation_unit_bilinear_stream.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/interpolation_unit_bilinear_stream_pkg.sv
// Shared types for the bilinear interpolator: FSM states, weight set and the
// per-feature weight calculation.
package interpolation_unit_pkg;
    localparam int IU_FRAC_W = 15;
    localparam int IU_WGT_W  = IU_FRAC_W + 1;
    localparam int IU_WPROD_W = 2 * IU_WGT_W;

    typedef enum logic [1:0] {IDLE, WEIGHT, STREAM, DRAIN} state_e;

    typedef struct packed {
        logic [IU_WGT_W-1:0] w00;
        logic [IU_WGT_W-1:0] w01;
        logic [IU_WGT_W-1:0] w10;
        logic [IU_WGT_W-1:0] w11;
    } weights_t;

    // w11 absorbs the truncation error so the four weights always sum to one.
    function automatic weights_t calc_weights(input logic [IU_FRAC_W-1:0] a,
                                              input logic [IU_FRAC_W-1:0] b);
        logic [IU_WPROD_W-1:0] one, aa, bb, na, nb;
        weights_t w;
        one   = IU_WPROD_W'(1) << IU_FRAC_W;
        aa    = IU_WPROD_W'(a);
        bb    = IU_WPROD_W'(b);
        na    = one - aa;
        nb    = one - bb;
        w.w00 = IU_WGT_W'((na * nb) >> IU_FRAC_W);
        w.w01 = IU_WGT_W'((aa * nb) >> IU_FRAC_W);
        w.w10 = IU_WGT_W'((na * bb) >> IU_FRAC_W);
        w.w11 = IU_WGT_W'(one) - w.w00 - w.w01 - w.w10;
        return w;
    endfunction
endpackage

// File: rtl/interpolation_unit_bilinear_stream_if.sv
// Feature, pixel-in and pixel-out handshakes of the bilinear interpolator.
interface interpolation_unit_bilinear_stream_if #(
    parameter int PIX_W  = 9,
    parameter int FRAC_W = 15,
    parameter int OUT_W  = PIX_W + FRAC_W
);
    logic [4:0]        win_dim;
    logic [FRAC_W-1:0] feat_x_dec;
    logic [FRAC_W-1:0] feat_y_dec;
    logic              feat_val;
    logic              feat_rdy;
    logic [PIX_W-1:0]  in_pix;
    logic              in_val;
    logic              in_rdy;
    logic [OUT_W-1:0]  out_msg;
    logic              out_last;
    logic              out_val;
    logic              out_rdy;

    modport master (
        output win_dim, feat_x_dec, feat_y_dec, feat_val, in_pix, in_val, out_rdy,
        input  feat_rdy, in_rdy, out_msg, out_last, out_val
    );
    modport slave (
        input  win_dim, feat_x_dec, feat_y_dec, feat_val, in_pix, in_val, out_rdy,
        output feat_rdy, in_rdy, out_msg, out_last, out_val
    );
endinterface

// File: rtl/interpolation_unit_bilinear_stream_linebuf.sv
// Register-array line buffer: synchronous write, combinational read.
module interpolation_unit_LineBuffer #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 17,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/interpolation_unit_bilinear_stream.sv
// Streaming bilinear interpolator: (W+1)^2 patch in, W^2 pixels out, 2-stage pipe.
// Optional INTERPOLATION_UNIT_OUT_ROUND_EN rounds the output to an integer pixel.
module interpolation_unit_bilinear_stream
    import interpolation_unit_pkg::*;
#(
    parameter int PIX_W   = 9,
    parameter int FRAC_W  = IU_FRAC_W,
    parameter int MAX_WIN = 16,
    parameter int OUT_W   = PIX_W + FRAC_W
) (
    input logic clk,
    input logic reset,
    interpolation_unit_bilinear_stream_if.slave bus
);
    localparam int WGT_W  = IU_WGT_W;
    localparam int PROD_W = WGT_W + PIX_W;
    localparam int SUM_W  = PROD_W + 2;
    localparam int AW     = $clog2(MAX_WIN + 1);
    localparam int STAGES = 2;

    state_e            state_q, state_d;
    logic [FRAC_W-1:0] a_q, b_q;
    logic [AW-1:0]     win_q, col_q, row_q, win_clamped;
    weights_t          wgt_q;
    logic [PIX_W-1:0]  top, ul_q, left_q;
    logic [PROD_W-1:0] p00_q, p01_q, p10_q, p11_q;
    logic [STAGES:1]   vld_pipe_q;
    logic              last1_q, out_last_q;
    logic [OUT_W-1:0]  out_msg_q, result;
    logic [SUM_W-1:0]  sum;
    logic              feat_rdy, in_rdy, stall, feat_acc, in_acc, last_pix, emit;

    assign stall    = vld_pipe_q[STAGES] & ~bus.out_rdy;
    assign feat_acc = bus.feat_val & feat_rdy;
    assign in_acc   = bus.in_val & in_rdy;
    assign last_pix = in_acc & (col_q == win_q) & (row_q == win_q);
    assign emit     = in_acc & (row_q != '0) & (col_q != '0);

    always_comb begin
        win_clamped = AW'(bus.win_dim);
        if (bus.win_dim == '0)                  win_clamped = AW'(1);
        else if (int'(bus.win_dim) > MAX_WIN)   win_clamped = AW'(MAX_WIN);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (bus.feat_val) state_d = WEIGHT;
            WEIGHT: state_d = STREAM;
            STREAM: if (last_pix) state_d = DRAIN;
            // Leave only once the last output has actually been handed over.
            DRAIN:  if (!vld_pipe_q[1] && !stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        feat_rdy = (state_q == IDLE);
        in_rdy   = (state_q == STREAM) & ~stall;
    end

    interpolation_unit_LineBuffer #(.WIDTH(PIX_W), .DEPTH(MAX_WIN + 1), .AW(AW)) u_lb (
        .clk     (clk),
        .we_i    (in_acc),
        .waddr_i (col_q),
        .wdata_i (bus.in_pix),
        .raddr_i (col_q),
        .rdata_o (top)
    );

    always_ff @(posedge clk) begin
        if (feat_acc) begin
            a_q   <= bus.feat_x_dec;
            b_q   <= bus.feat_y_dec;
            win_q <= win_clamped;
        end
        if (state_q == WEIGHT) wgt_q <= calc_weights(a_q, b_q);
        if (in_acc) begin
            ul_q   <= top;
            left_q <= bus.in_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || feat_acc) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_acc) begin
            if (col_q == win_q) begin
                col_q <= '0;
                row_q <= (row_q == win_q) ? '0 : row_q + AW'(1);
            end else begin
                col_q <= col_q + AW'(1);
            end
        end
    end

    assign sum = SUM_W'(p00_q) + SUM_W'(p01_q) + SUM_W'(p10_q) + SUM_W'(p11_q);
`ifdef INTERPOLATION_UNIT_OUT_ROUND_EN
    assign result = OUT_W'((sum + (SUM_W'(1) << (FRAC_W - 1))) >> FRAC_W);
`else
    assign result = OUT_W'(sum);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            last1_q    <= 1'b0;
            out_last_q <= 1'b0;
            out_msg_q  <= '0;
        end else if (!stall) begin
            vld_pipe_q[1] <= emit;
            last1_q       <= last_pix;
            p00_q         <= PROD_W'(wgt_q.w00) * PROD_W'(ul_q);
            p01_q         <= PROD_W'(wgt_q.w01) * PROD_W'(top);
            p10_q         <= PROD_W'(wgt_q.w10) * PROD_W'(left_q);
            p11_q         <= PROD_W'(wgt_q.w11) * PROD_W'(bus.in_pix);
            vld_pipe_q[2] <= vld_pipe_q[1];
            out_last_q    <= vld_pipe_q[1] & last1_q;
            if (vld_pipe_q[1]) out_msg_q <= result;
        end
    end

    assign bus.feat_rdy = feat_rdy;
    assign bus.in_rdy   = in_rdy;
    assign bus.out_val  = vld_pipe_q[STAGES];
    assign bus.out_last = out_last_q;
    assign bus.out_msg  = out_msg_q;
endmodule

// File: tb/tb_interpolation_unit_bilinear_stream.sv
// Self-checking bench: directed known answers plus randomized patches against
// a per-output bilinear formula evaluated on a 2-D pixel array.
module tb_interpolation_unit_bilinear_stream;
    localparam int PIX_W = 9;
    localparam int FRAC_W = 15;
    localparam int OUT_W = PIX_W + FRAC_W;
    localparam int ONE = 1 << FRAC_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interpolation_unit_bilinear_stream_if #(.PIX_W(PIX_W), .FRAC_W(FRAC_W)) bus ();

    interpolation_unit_bilinear_stream #(
        .PIX_W(PIX_W), .FRAC_W(FRAC_W), .MAX_WIN(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pix_q[$];
    logic [OUT_W-1:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feature handshake followed by a look at the single weight cycle.
    task automatic do_feat(input int a, input int b, input int wd);
        logic ok;
        @(negedge clk);
        bus.feat_val = 1'b1;
        bus.feat_x_dec = 15'(a);
        bus.feat_y_dec = 15'(b);
        bus.win_dim = 5'(wd);
        bus.in_val = 1'b0;
        bus.out_rdy = 1'b1;
        ok = 1'b0;
        for (int g = 0; g < 50; g++) begin
            #1;
            if (bus.feat_rdy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("feat_accept", ok, 1);
        @(posedge clk);
        @(negedge clk);
        bus.feat_val = 1'b0;
        #1;
        chk("weight_cycle_rdys", {bus.feat_rdy, bus.in_rdy}, 2'b00);
    endtask

    // mode 0: free flow, 1: random in_val/out_rdy, 2: 5-cycle stall at 3rd output
    task automatic run_feature(input int a, input int b, input int wd, input int mode);
        int W, total, nexp, pi, nout, hold, extra, s;
        int w00, w01, w10, w11;
        int exp_msg[$], exp_src[$], acc_cyc[$];
        logic exp_last[$];
        logic prev_stall, prev_last, ordy, ok;
        logic [OUT_W-1:0] prev_msg;

        W = (wd < 1) ? 1 : (wd > 16) ? 16 : wd;
        total = (W + 1) * (W + 1);
        w00 = ((ONE - a) * (ONE - b)) >> FRAC_W;
        w01 = (a * (ONE - b)) >> FRAC_W;
        w10 = ((ONE - a) * b) >> FRAC_W;
        w11 = ONE - w00 - w01 - w10;
        for (int r = 1; r <= W; r++)
            for (int c = 1; c <= W; c++) begin
                s = w00 * pix_q[(r-1)*(W+1) + c-1] + w01 * pix_q[(r-1)*(W+1) + c]
                  + w10 * pix_q[r*(W+1) + c-1]     + w11 * pix_q[r*(W+1) + c];
`ifdef INTERPOLATION_UNIT_OUT_ROUND_EN
                s = (s + ONE / 2) / ONE;
`endif
                exp_msg.push_back(s);
                exp_last.push_back(r == W && c == W);
                exp_src.push_back(r * (W + 1) + c);
            end
        nexp = exp_msg.size();

        do_feat(a, b, wd);
        pi = 0; nout = 0; hold = 0; prev_stall = 1'b0; prev_msg = '0; prev_last = 1'b0;
        for (int t = 0; t < 3000 && nout < nexp; t++) begin
            @(negedge clk);
            ordy = 1'b1;
            if (mode == 1) ordy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && bus.out_val && nout == 2 && hold < 5) begin
                ordy = 1'b0;
                hold++;
            end
            bus.out_rdy = ordy;
            if (pi < total && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                bus.in_val = 1'b1;
                bus.in_pix = 9'(pix_q[pi]);
            end else begin
                bus.in_val = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("hold_val", bus.out_val, 1);
                chk("hold_msg", bus.out_msg, prev_msg);
                chk("hold_last", bus.out_last, prev_last);
            end
            if (bus.out_val && !bus.out_rdy) chk("stall_in_rdy", bus.in_rdy, 0);
            if (bus.in_val && bus.in_rdy) begin
                acc_cyc.push_back(cyc);
                pi++;
            end
            if (bus.out_val && bus.out_rdy) begin
                chk("out_msg", bus.out_msg, exp_msg[nout]);
                chk("out_last", bus.out_last, exp_last[nout]);
                if (mode == 0) chk("latency", cyc, acc_cyc[exp_src[nout]] + 2);
                got_q.push_back(bus.out_msg);
                nout++;
            end
            prev_stall = bus.out_val & ~bus.out_rdy;
            prev_msg = bus.out_msg;
            prev_last = bus.out_last;
        end
        chk("out_count", nout, nexp);
        chk("pix_count", pi, total);

        ok = 1'b0; extra = 0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            bus.in_val = 1'b0;
            bus.out_rdy = 1'b1;
            #1;
            if (bus.out_val) extra++;
            if (bus.feat_rdy) begin ok = 1'b1; break; end
        end
        chk("back_to_idle", ok, 1);
        chk("no_extra_out", extra, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.feat_val = 1'b0; bus.feat_x_dec = '0; bus.feat_y_dec = '0; bus.win_dim = '0;
        bus.in_val = 1'b0; bus.in_pix = '0; bus.out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_out_val", bus.out_val, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_msg", bus.out_msg, 0);
        chk("rst_in_rdy", bus.in_rdy, 0);
        chk("rst_feat_rdy", bus.feat_rdy, 1);
        reset = 1'b0;

`ifndef INTERPOLATION_UNIT_OUT_ROUND_EN
        pix_q.delete(); got_q.delete();
        for (int i = 0; i < 9; i++) pix_q.push_back(i);
        run_feature(0, 0, 2, 0);
        chk("kat_ramp_n", got_q.size(), 4);
        chk("kat_ramp0", got_q[0], 24'h0);
        chk("kat_ramp1", got_q[1], 24'h8000);
        chk("kat_ramp2", got_q[2], 24'h18000);
        chk("kat_ramp3", got_q[3], 24'h20000);

        pix_q.delete(); got_q.delete();
        for (int i = 0; i < 4; i++) pix_q.push_back(100);
        run_feature(16'h4000, 16'h4000, 1, 0);
        chk("kat_flat", got_q[0], 24'h320000);

        pix_q.delete(); got_q.delete();
        pix_q = '{0, 2, 4, 6};
        run_feature(16'h4000, 0, 1, 0);
        chk("kat_half_x", got_q[0], 24'h8000);
`else
        pix_q.delete(); got_q.delete();
        pix_q = '{0, 0, 0, 1};
        run_feature(16'h4000, 16'h4000, 1, 0);
        chk("kat_round_down", got_q[0], 24'h0);
        pix_q.delete(); got_q.delete();
        pix_q = '{0, 1, 1, 1};
        run_feature(16'h4000, 16'h4000, 1, 0);
        chk("kat_round_up", got_q[0], 24'h1);
`endif

        pix_q.delete(); got_q.delete();
        for (int i = 0; i < 25; i++) pix_q.push_back((i * 7) % 512);
        run_feature(16'h1a00, 16'h5300, 4, 2);
        chk("stall_run_n", got_q.size(), 16);

        // Abort a patch part-way with reset, then run a clean one.
        pix_q.delete();
        do_feat(16'h1234, 16'h0321, 3);
        n = 0;
        for (int g = 0; g < 100 && n < 7; g++) begin
            @(negedge clk);
            bus.in_val = 1'b1;
            bus.in_pix = 9'(n + 10);
            bus.out_rdy = 1'b1;
            #1;
            if (bus.in_rdy) n++;
        end
        chk("rst_pix_fed", n, 7);
        @(negedge clk);
        bus.in_val = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_feat_rdy", bus.feat_rdy, 1);
        chk("midrst_out_val", bus.out_val, 0);
        chk("midrst_in_rdy", bus.in_rdy, 0);
        pix_q.delete();
        for (int i = 0; i < 4; i++) pix_q.push_back($urandom_range(0, 511));
        run_feature(16'h2000, 16'h6000, 1, 0);

        // Largest window, largest fractions, saturated pixels.
        pix_q.delete();
        for (int i = 0; i < 289; i++) pix_q.push_back(511);
        run_feature(16'h7fff, 16'h7fff, 16, 0);

        for (int k = 0; k < 6; k++) begin
            int wd, W;
            wd = (k == 0) ? 0 : (k == 1) ? 20 : $urandom_range(1, 8);
            W = (wd < 1) ? 1 : (wd > 16) ? 16 : wd;
            pix_q.delete();
            for (int i = 0; i < (W + 1) * (W + 1); i++) pix_q.push_back($urandom_range(0, 511));
            run_feature($urandom_range(0, ONE - 1), $urandom_range(0, ONE - 1), wd, k % 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
